// File: rtl/controller_poller_pkg.sv
// Shared constants for the NES-style pad poller.
//   state_e      : poller FSM encodings (3 bits).
//   BTN_A..BTN_RIGHT : bit positions of each button on the committed controller bus.
//                  The button-value logic reuses these positions.
package controller_poller_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLatch   = 3'd1,
    StPulseHi = 3'd2,
    StPulseLo = 3'd3,
    StCommit  = 3'd4
  } state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned NUM_BTN = 8;

endpackage

// File: rtl/controller_poller_if.sv
// Bundle of pad pins and M-stage signals around the controller poller.
//   pad_data      : serial data from pad, active-low (0 = pressed)
//   pad_latch     : latch pulse to pad
//   pad_clk       : shift clock to pad
//   clear_pressed : one-cycle strobe from M stage (sbp retire)
//   clear_mask    : bits of pressed to clear with clear_pressed
//   controller    : committed button state, active-high
//   pressed       : sticky rising-edge flags
//   valid         : one-cycle pulse when controller is committed
// master = poller side, slave = pad + memory stage side.
interface controller_poller_if;

  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic       clear_pressed;
  logic [7:0] clear_mask;
  logic [7:0] controller;
  logic [7:0] pressed;
  logic       valid;

  modport master (
    input  pad_data,
    input  clear_pressed,
    input  clear_mask,
    output pad_latch,
    output pad_clk,
    output controller,
    output pressed,
    output valid
  );

  modport slave (
    output pad_data,
    output clear_pressed,
    output clear_mask,
    input  pad_latch,
    input  pad_clk,
    input  controller,
    input  pressed,
    input  valid
  );

endinterface

// File: rtl/controller_poller_sync2.sv
// Two-flop synchroniser for the asynchronous pad data pin.
//   clock : system clock
//   reset : asynchronous active-high reset (both flops clear to 0)
//   d_i   : asynchronous input
//   q_o   : synchronised output, two cycles late
module controller_poller_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/controller_poller.sv
// Serial game-pad poller. Periodically latches the pad, clocks out 8 button bits
// (bit 0 first, active-low on the wire) and commits them to a stable parallel bus.
// Also keeps sticky "pressed since last consumed" flags cleared by the M stage.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-high
//   pad_bus : controller_poller_if.master (pad pins, clear strobe/mask,
//             controller, pressed, valid)
// Poll timing: POLL_PERIOD idle cycles, latch for 2*CLK_DIV cycles, 7 pad_clk pulses of
// CLK_DIV high + CLK_DIV low, then one COMMIT cycle.
module controller_poller
  import controller_poller_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned POLL_PERIOD = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  controller_poller_if.master pad_bus
);

  localparam logic [CNT_W-1:0] IdleLast  = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] LatchLast = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HalfLast  = CNT_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       controller_q, controller_d;
  logic [7:0]       edge_q, edge_d;
  logic [7:0]       pressed_q, pressed_d;
  logic             valid_q, valid_d;
  logic             pad_latch_q, pad_latch_d;
  logic             pad_clk_q, pad_clk_d;
  logic             pad_sync;
  logic             enter_commit;
  logic [7:0]       clr;

  controller_poller_sync2 u_sync2 (
    .clock (clock),
    .reset (reset),
    .d_i   (pad_bus.pad_data),
    .q_o   (pad_sync)
  );

  // Sequencing: one shared counter times every phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (cnt_q == IdleLast) begin
          state_d = StLatch;
          cnt_d   = '0;
        end
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          shift_d[0] = pad_sync;
          idx_d      = 3'd1;
          state_d    = StPulseHi;
          cnt_d      = '0;
        end
      end
      StPulseHi: begin
        if (cnt_q == HalfLast) begin
          state_d = StPulseLo;
          cnt_d   = '0;
        end
      end
      StPulseLo: begin
        if (cnt_q == HalfLast) begin
          // Sample at phase end so the synchroniser delay is hidden.
          shift_d[idx_q] = pad_sync;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = StCommit;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StPulseHi;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Commit and sticky-flag logic. controller and valid are loaded on the edge entering
  // COMMIT so they appear together in the COMMIT cycle; the new-edge flags are captured
  // against the old controller value at the same time and merged into pressed on the edge
  // leaving COMMIT, which lets a clear strobe in the COMMIT cycle lose to a new edge.
  always_comb begin
    enter_commit = (state_d == StCommit) && (state_q != StCommit);
    clr          = pad_bus.clear_pressed ? pad_bus.clear_mask : 8'h00;

    controller_d = controller_q;
    edge_d       = edge_q;
    if (enter_commit) begin
      controller_d = ~shift_d;
      edge_d       = ~shift_d & ~controller_q;
    end

    pressed_d = pressed_q & ~clr;
    if (state_q == StCommit) begin
      pressed_d = pressed_d | edge_q;
    end

    valid_d     = enter_commit;
    pad_latch_d = (state_d == StLatch);
    pad_clk_d   = (state_d == StPulseHi);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      controller_q <= 8'h00;
      edge_q       <= 8'h00;
      pressed_q    <= 8'h00;
      valid_q      <= 1'b0;
      pad_latch_q  <= 1'b0;
      pad_clk_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      controller_q <= controller_d;
      edge_q       <= edge_d;
      pressed_q    <= pressed_d;
      valid_q      <= valid_d;
      pad_latch_q  <= pad_latch_d;
      pad_clk_q    <= pad_clk_d;
    end
  end

  assign pad_bus.pad_latch  = pad_latch_q;
  assign pad_bus.pad_clk    = pad_clk_q;
  assign pad_bus.controller = controller_q;
  assign pad_bus.pressed    = pressed_q;
  assign pad_bus.valid      = valid_q;

endmodule

// File: tb/tb_controller_poller.sv
module tb_controller_poller;
  import controller_poller_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset1;
  logic       reset2;
  logic [7:0] btn1;
  logic [2:0] pad_idx1 = 3'd0;
  logic       pad2;

  controller_poller_if bus1 ();
  controller_poller_if bus2 ();

  controller_poller #(.CLK_DIV(2), .POLL_PERIOD(10), .CNT_W(8)) u_dut1 (
    .clock   (clock),
    .reset   (reset1),
    .pad_bus (bus1.master)
  );

  controller_poller #(.CLK_DIV(1), .POLL_PERIOD(1), .CNT_W(4)) u_dut2 (
    .clock   (clock),
    .reset   (reset2),
    .pad_bus (bus2.master)
  );

  // Pad model: latch selects bit 0, each pad_clk rise advances one bit; active-low wire.
  always @(posedge bus1.pad_latch or posedge bus1.pad_clk) begin
    if (bus1.pad_latch) pad_idx1 <= 3'd0;
    else                pad_idx1 <= pad_idx1 + 3'd1;
  end
  assign bus1.pad_data = ~btn1[pad_idx1];
  assign bus2.pad_data = pad2;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] btn;
    logic [7:0] commit_clr;
    logic [7:0] post_clr;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_pressed;
    logic [7:0] exp_after;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_valid1(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (bus1.valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         latch_first, latch_cnt, clk_rises, clk_high, valid_c, valid_seen;
    logic       prev_clk;
    logic [7:0] ctrl_at_valid;
    logic [7:0] ab_mask;

    ab_mask = 8'h00;
    ab_mask[BTN_A]  = 1'b1;
    ab_mask[BTN_UP] = 1'b1;

    vecs[0] = '{ab_mask, 8'h00, 8'h00, 8'h11, 8'h11, 8'h00};
    vecs[1] = '{8'h11,   8'h00, 8'h01, 8'h11, 8'h11, 8'h10};
    vecs[2] = '{8'h10,   8'h00, 8'h00, 8'h10, 8'h10, 8'h00};
    vecs[3] = '{8'h11,   8'hFF, 8'h00, 8'h11, 8'h01, 8'h00};
    vecs[4] = '{8'h00,   8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    vecs[5] = '{8'hA5,   8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h00};
    vecs[6] = '{8'hFF,   8'h00, 8'h00, 8'hFF, 8'h5A, 8'h00};
    vecs[7] = '{8'h3C,   8'h0F, 8'h00, 8'h3C, 8'h50, 8'h00};

    reset1 = 1'b1;
    reset2 = 1'b1;
    btn1   = 8'h00;
    pad2   = 1'b1;
    bus1.clear_pressed = 1'b0;
    bus1.clear_mask    = 8'h00;
    bus2.clear_pressed = 1'b0;
    bus2.clear_mask    = 8'h00;
    #1;
    check("rst_latch", {31'd0, bus1.pad_latch}, 32'd0);
    check("rst_clk",   {31'd0, bus1.pad_clk},   32'd0);
    check("rst_valid", {31'd0, bus1.valid},     32'd0);
    check("rst_ctrl",  {24'd0, bus1.controller}, 32'd0);
    check("rst_press", {24'd0, bus1.pressed},   32'd0);
    repeat (3) @(posedge clock);

    // First poll: timing against reset release, pad idle (no buttons).
    @(negedge clock);
    reset1 = 1'b0;
    latch_first = 0; latch_cnt = 0; clk_rises = 0; clk_high = 0; valid_c = 0;
    prev_clk = 1'b0; ctrl_at_valid = 8'hEE;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clock);
      #1;
      if (bus1.pad_latch) begin
        latch_cnt++;
        if (latch_first == 0) latch_first = c;
      end
      if (bus1.pad_clk) clk_high++;
      if (bus1.pad_clk && !prev_clk) clk_rises++;
      prev_clk = bus1.pad_clk;
      if (bus1.valid) begin
        valid_c = c;
        ctrl_at_valid = bus1.controller;
      end
    end
    check("first_latch_cycle", latch_first, 32'd10);
    check("latch_len",         latch_cnt,   32'd4);
    check("clk_pulses",        clk_rises,   32'd7);
    check("clk_high_cycles",   clk_high,    32'd14);
    check("valid_cycle",       valid_c,     32'd42);
    check("idle_ctrl",         {24'd0, ctrl_at_valid}, 32'd0);
    check("idle_press",        {24'd0, bus1.pressed},  32'd0);

    // Table-driven polls.
    foreach (vecs[i]) begin
      btn1 = vecs[i].btn;
      wait_valid1($sformatf("v%0d", i), ok);
      if (ok) begin
        check($sformatf("v%0d_ctrl", i), {24'd0, bus1.controller}, {24'd0, vecs[i].exp_ctrl});
        if (vecs[i].commit_clr != 8'h00) begin
          bus1.clear_pressed = 1'b1;
          bus1.clear_mask    = vecs[i].commit_clr;
        end
        @(posedge clock);
        #1;
        bus1.clear_pressed = 1'b0;
        check($sformatf("v%0d_valid_pulse", i), {31'd0, bus1.valid}, 32'd0);
        check($sformatf("v%0d_press", i), {24'd0, bus1.pressed}, {24'd0, vecs[i].exp_pressed});
        if (vecs[i].post_clr != 8'h00) begin
          bus1.clear_pressed = 1'b1;
          bus1.clear_mask    = vecs[i].post_clr;
          @(posedge clock);
          #1;
          bus1.clear_pressed = 1'b0;
          check($sformatf("v%0d_clear", i), {24'd0, bus1.pressed}, {24'd0, vecs[i].exp_after});
        end
      end
    end

    // Reset during the 4th pad_clk pulse of a poll.
    btn1 = 8'hC3;
    clk_rises = 0;
    prev_clk  = bus1.pad_clk;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (bus1.pad_clk && !prev_clk) clk_rises++;
      prev_clk = bus1.pad_clk;
      if (clk_rises == 4) break;
    end
    check("mid_pulse4_reached", clk_rises, 32'd4);
    reset1 = 1'b1;
    #1;
    check("mid_rst_clk",   {31'd0, bus1.pad_clk},   32'd0);
    check("mid_rst_latch", {31'd0, bus1.pad_latch}, 32'd0);
    check("mid_rst_valid", {31'd0, bus1.valid},     32'd0);
    check("mid_rst_ctrl",  {24'd0, bus1.controller}, 32'd0);
    check("mid_rst_press", {24'd0, bus1.pressed},   32'd0);
    @(negedge clock);
    reset1 = 1'b0;
    latch_first = 0;
    valid_seen  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (bus1.valid) valid_seen++;
      if (bus1.pad_latch) begin
        latch_first = c;
        break;
      end
    end
    check("post_rst_latch_cycle", latch_first, 32'd10);
    check("aborted_no_commit",    valid_seen,  32'd0);
    wait_valid1("post_rst", ok);
    if (ok) begin
      check("post_rst_ctrl", {24'd0, bus1.controller}, 32'h0000_00C3);
      @(posedge clock);
      #1;
      check("post_rst_press", {24'd0, bus1.pressed}, 32'h0000_00C3);
    end

    // Back-to-back polls, CLK_DIV=1, POLL_PERIOD=1; pad level flips once per poll.
    begin
      int         k;
      int         rises2;
      logic       prev2;
      bit         pend;
      logic [7:0] exp_pr;
      k = 0; rises2 = 0; prev2 = 1'b0; pend = 1'b0; exp_pr = 8'h00;
      @(negedge clock);
      reset2 = 1'b0;
      for (int c = 1; c <= 80; c++) begin
        @(posedge clock);
        #1;
        if (bus2.pad_clk && !prev2) rises2++;
        prev2 = bus2.pad_clk;
        if (pend) begin
          check($sformatf("b2b%0d_press", k - 1), {24'd0, bus2.pressed}, {24'd0, exp_pr});
          pend = 1'b0;
        end
        if (bus2.valid) begin
          check($sformatf("b2b%0d_cycle", k), c, 17 + 18 * k);
          check($sformatf("b2b%0d_ctrl", k), {24'd0, bus2.controller},
                (k % 2 == 1) ? 32'h0000_00FF : 32'h0000_0000);
          check($sformatf("b2b%0d_pulses", k), rises2, 32'd7);
          exp_pr = (k == 0) ? 8'h00 : 8'hFF;
          rises2 = 0;
          pad2   = ~pad2;
          pend   = 1'b1;
          k++;
        end
      end
      check("b2b_count", k, 32'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
